// File: rtl/vx_dram_responder.sv
// DRAM line responder: byte-masked writes into a small line memory, reads return
// in order after a fixed latency through a bounded queue of countdown slots.

module vx_dram_rsp_slot #(
    parameter int DATA_WIDTH = 512,
    parameter int TAG_WIDTH  = 8,
    parameter int CNT_W      = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic [TAG_WIDTH-1:0]  load_tag,
    input  logic [CNT_W-1:0]      load_cnt,
    output logic [DATA_WIDTH-1:0] data,
    output logic [TAG_WIDTH-1:0]  tag,
    output logic                  done
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt  <= '0;
            data <= '0;
            tag  <= '0;
        end else if (load) begin
            cnt  <= load_cnt;
            data <= load_data;
            tag  <= load_tag;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign done = (cnt == '0);

endmodule

module vx_dram_responder #(
    parameter int DATA_WIDTH    = 512,
    parameter int ADDR_WIDTH    = 26,
    parameter int TAG_WIDTH     = 8,
    parameter int MEM_ADDR_BITS = 6,
    parameter int LATENCY       = 4,
    parameter int QUEUE_SIZE    = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    dram_req_valid,
    input  logic                    dram_req_rw,
    input  logic [DATA_WIDTH/8-1:0] dram_req_byteen,
    input  logic [ADDR_WIDTH-1:0]   dram_req_addr,
    input  logic [DATA_WIDTH-1:0]   dram_req_data,
    input  logic [TAG_WIDTH-1:0]    dram_req_tag,
    output logic                    dram_req_ready,
    output logic                    dram_rsp_valid,
    output logic [DATA_WIDTH-1:0]   dram_rsp_data,
    output logic [TAG_WIDTH-1:0]    dram_rsp_tag,
    input  logic                    dram_rsp_ready,
    output logic                    busy
);

    localparam int NUM_BYTES = DATA_WIDTH / 8;
    localparam int MEM_LINES = 1 << MEM_ADDR_BITS;
    localparam int QW        = $clog2(QUEUE_SIZE);
    localparam int CNT_W     = 4;

    typedef struct packed {
        logic                     rw;
        logic [NUM_BYTES-1:0]     byteen;
        logic [MEM_ADDR_BITS-1:0] idx;
        logic [DATA_WIDTH-1:0]    data;
        logic [TAG_WIDTH-1:0]     tag;
    } req_t;

    req_t req;
    assign req.rw     = dram_req_rw;
    assign req.byteen = dram_req_byteen;
    assign req.idx    = dram_req_addr[MEM_ADDR_BITS-1:0];
    assign req.data   = dram_req_data;
    assign req.tag    = dram_req_tag;

    // Upper address bits alias onto the same lines by design.
    logic addr_unused;
    assign addr_unused = ^dram_req_addr[ADDR_WIDTH-1:MEM_ADDR_BITS];

    logic [DATA_WIDTH-1:0] mem [MEM_LINES];

    logic [QW-1:0] wr_ptr, rd_ptr;
    logic [QW:0]   count;
    logic          full, req_fire, rd_acc, wr_acc, pop;

    logic [QUEUE_SIZE-1:0][DATA_WIDTH-1:0] slot_data;
    logic [QUEUE_SIZE-1:0][TAG_WIDTH-1:0]  slot_tag;
    logic [QUEUE_SIZE-1:0]                 slot_done;
    logic [QUEUE_SIZE-1:0]                 slot_load;

    assign full           = (count == (QW+1)'(QUEUE_SIZE));
    assign dram_req_ready = !full;
    assign req_fire       = dram_req_valid && dram_req_ready;
    assign rd_acc         = req_fire && !req.rw;
    assign wr_acc         = req_fire && req.rw;
    assign busy           = (count != '0);
    assign dram_rsp_valid = busy && slot_done[rd_ptr];
    assign pop            = dram_rsp_valid && dram_rsp_ready;
    assign dram_rsp_data  = busy ? slot_data[rd_ptr] : '0;
    assign dram_rsp_tag   = busy ? slot_tag[rd_ptr]  : '0;

    // Line storage is intentionally left unreset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (req.byteen[i])
                    mem[req.idx][i*8 +: 8] <= req.data[i*8 +: 8];
            end
        end
    end

    generate
        for (genvar g = 0; g < QUEUE_SIZE; g++) begin : g_slot
            assign slot_load[g] = rd_acc && (wr_ptr == QW'(g));

            vx_dram_rsp_slot #(
                .DATA_WIDTH (DATA_WIDTH),
                .TAG_WIDTH  (TAG_WIDTH),
                .CNT_W      (CNT_W)
            ) u_slot (
                .clk       (clk),
                .reset     (reset),
                .load      (slot_load[g]),
                .load_data (mem[req.idx]),
                .load_tag  (req.tag),
                .load_cnt  (CNT_W'(LATENCY - 1)),
                .data      (slot_data[g]),
                .tag       (slot_tag[g]),
                .done      (slot_done[g])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (rd_acc) wr_ptr <= wr_ptr + QW'(1);
            if (pop)    rd_ptr <= rd_ptr + QW'(1);
            case ({rd_acc, pop})
                2'b10:   count <= count + (QW+1)'(1);
                2'b01:   count <= count - (QW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_vx_dram_responder.sv
// Scoreboard bench for vx_dram_responder: a line-level reference memory plus an
// ordered queue of expected reads, checked cycle by cycle by an independent monitor.

module tb_vx_dram_responder;

    localparam int DW  = 512;
    localparam int AW  = 26;
    localparam int TW  = 8;
    localparam int MB  = 6;
    localparam int LAT = 4;
    localparam int QS  = 4;

    logic          clk = 0;
    logic          reset = 1;
    logic          dram_req_valid = 0;
    logic          dram_req_rw = 0;
    logic [DW/8-1:0] dram_req_byteen = '0;
    logic [AW-1:0] dram_req_addr = '0;
    logic [DW-1:0] dram_req_data = '0;
    logic [TW-1:0] dram_req_tag = '0;
    logic          dram_req_ready;
    logic          dram_rsp_valid;
    logic [DW-1:0] dram_rsp_data;
    logic [TW-1:0] dram_rsp_tag;
    logic          dram_rsp_ready = 0;
    logic          busy;

    vx_dram_responder #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW),
        .MEM_ADDR_BITS(MB), .LATENCY(LAT), .QUEUE_SIZE(QS)
    ) dut (
        .clk(clk), .reset(reset),
        .dram_req_valid(dram_req_valid), .dram_req_rw(dram_req_rw),
        .dram_req_byteen(dram_req_byteen), .dram_req_addr(dram_req_addr),
        .dram_req_data(dram_req_data), .dram_req_tag(dram_req_tag),
        .dram_req_ready(dram_req_ready),
        .dram_rsp_valid(dram_rsp_valid), .dram_rsp_data(dram_rsp_data),
        .dram_rsp_tag(dram_rsp_tag), .dram_rsp_ready(dram_rsp_ready),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic [TW-1:0] tag;
        int            acc;
    } exp_t;

    exp_t          sbq[$];
    logic [DW-1:0] ref_mem [64];
    int            cyc = 0;
    int            vectors = 0;
    int            miscompares = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0h want %0h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_line();
        logic [DW-1:0] l;
        for (int i = 0; i < DW/32; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    // Called just after a falling edge; acceptance happens at the next rising edge.
    task automatic drive(input bit v, input bit rw, input logic [AW-1:0] a,
                         input logic [DW/8-1:0] be, input logic [DW-1:0] d,
                         input logic [TW-1:0] t, output bit acc);
        int idx;
        dram_req_valid  = v;
        dram_req_rw     = rw;
        dram_req_addr   = a;
        dram_req_byteen = be;
        dram_req_data   = d;
        dram_req_tag    = t;
        acc = v && dram_req_ready;
        if (acc) begin
            idx = int'(a % 64);
            if (rw) begin
                for (int i = 0; i < DW/8; i++)
                    if (be[i]) ref_mem[idx][i*8 +: 8] = d[i*8 +: 8];
            end else begin
                sbq.push_back('{data: ref_mem[idx], tag: t, acc: cyc + 1});
            end
        end
    endtask

    task automatic send(input bit rw, input logic [AW-1:0] a, input logic [DW/8-1:0] be,
                        input logic [DW-1:0] d, input logic [TW-1:0] t);
        bit acc = 0;
        int n = 0;
        do begin
            @(negedge clk);
            drive(1'b1, rw, a, be, d, t, acc);
            n++;
        end while (!acc && n < 200);
        if (!acc) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: request tag %0h never accepted", t);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        dram_req_valid = 0;
    endtask

    task automatic drain();
        int n = 0;
        dram_rsp_ready = 1;
        while (sbq.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain_left", 32'(sbq.size()), 0);
    endtask

    // Monitor: an entry is outstanding once its accept edge has passed; the head is
    // valid from LATENCY-1 edges after acceptance until it pops.
    bit            stall_prev = 0;
    logic [DW-1:0] prev_data;
    logic [TW-1:0] prev_tag;

    always begin
        int  outst;
        bit  exp_v;
        @(negedge clk);
        #1;
        outst = 0;
        foreach (sbq[i]) if (sbq[i].acc <= cyc) outst++;
        exp_v = (sbq.size() > 0) && (sbq[0].acc <= cyc) && (cyc >= sbq[0].acc + LAT - 1);
        chk("rsp_valid", dram_rsp_valid, exp_v);
        chk("busy", busy, outst != 0);
        chk("req_ready", dram_req_ready, outst < QS);
        if (outst == 0) begin
            chk("idle_data", dram_rsp_data, 0);
            chk("idle_tag", dram_rsp_tag, 0);
        end
        if (stall_prev && dram_rsp_valid) begin
            chk("hold_data", dram_rsp_data, prev_data);
            chk("hold_tag", dram_rsp_tag, prev_tag);
        end
        stall_prev = dram_rsp_valid && !dram_rsp_ready;
        prev_data  = dram_rsp_data;
        prev_tag   = dram_rsp_tag;
        if (dram_rsp_valid && dram_rsp_ready && exp_v) begin
            chk("rsp_data", dram_rsp_data, sbq[0].data);
            chk("rsp_tag", dram_rsp_tag, sbq[0].tag);
            void'(sbq.pop_front());
        end
    end

    initial begin
        bit acc;
        logic [DW-1:0] d;

        #1;
        chk("rst_ready", dram_req_ready, 1);
        chk("rst_valid", dram_rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_data", dram_rsp_data, 0);
        chk("rst_tag", dram_rsp_tag, 0);
        repeat (2) @(negedge clk);
        reset = 0;

        for (int i = 0; i < 64; i++) send(1'b1, AW'(i), '1, rand_line(), 8'h0);
        idle();

        dram_rsp_ready = 1;
        send(1'b1, 26'd5, '1, {64{8'hA5}}, 8'h0);
        send(1'b0, 26'd5, '0, '0, 8'h11);
        idle();
        drain();

        send(1'b1, 26'd3, '1, '0, 8'h0);
        d = rand_line();
        d[7:0] = 8'hFF;
        send(1'b1, 26'd3, 64'h1, d, 8'h0);
        send(1'b0, 26'd3, '0, '0, 8'h37);
        send(1'b0, 26'h45, '0, '0, 8'h41);
        idle();
        drain();

        // Fill the queue with the consumer stalled, then release it.
        dram_rsp_ready = 0;
        for (int i = 0; i < 4; i++) send(1'b0, AW'($urandom), '0, '0, TW'(8'h20 + i));
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            drive(1'b1, 1'b0, 26'd9, '0, '0, 8'h24, acc);
            chk("full_stall", acc, 0);
        end
        dram_rsp_ready = 1;
        send(1'b0, 26'd9, '0, '0, 8'h24);
        idle();
        drain();

        for (int i = 0; i < 8; i++) send(1'b0, AW'($urandom), '0, '0, TW'(i));
        idle();
        drain();

        // Reset with three reads in flight.
        dram_rsp_ready = 0;
        for (int i = 0; i < 3; i++) send(1'b0, AW'(i), '0, '0, TW'(8'h50 + i));
        @(negedge clk);
        dram_req_valid = 0;
        reset = 1;
        sbq.delete();
        #1;
        chk("mid_rst_valid", dram_rsp_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", dram_req_ready, 1);
        repeat (2) @(negedge clk);
        reset = 0;
        dram_rsp_ready = 1;
        repeat (10) @(negedge clk);

        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            dram_rsp_ready = ($urandom_range(9) < 7);
            drive($urandom_range(3) != 0, $urandom_range(1) == 1, AW'($urandom),
                  {$urandom, $urandom}, rand_line(), TW'($urandom), acc);
        end
        idle();
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
